// File: rtl/bsg_arb_pkg.sv
// Shared definitions for the round-robin arbitration blocks.
package bsg_arb_pkg;

  // Arbiter control states: waiting for a request, or holding a grant.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Width of a binary requester id; at least one bit so tiny arrays stay legal.
  function automatic int id_width(input int els);
    return (els > 1) ? $clog2(els) : 1;
  endfunction

endpackage

// File: rtl/bsg_decode_with_v.sv
// Shared one-hot decoder with a valid gate: all zeros when v_i is low.
module bsg_decode_with_v #(
  parameter int num_out_p = 32,
  localparam int lg_num_out_lp = (num_out_p > 1) ? $clog2(num_out_p) : 1
) (
  input  logic [lg_num_out_lp-1:0] i,
  input  logic                     v_i,
  output logic [num_out_p-1:0]     o
);

  // Place a single one at position i when valid.
  always_comb begin
    if (v_i) begin
      o = num_out_p'(1) << i;
    end else begin
      o = '0;
    end
  end

endmodule

// File: rtl/bsg_rr_decode_arb_chk.sv
// Simulation-only protocol checks for bsg_rr_decode_arb.
module bsg_rr_decode_arb_chk #(
  parameter int els_p = 32
) (
  input logic             clk_i,
  input logic             reset_n_i,
  input logic             yumi_i,
  input logic             grant_v_i,
  input logic [els_p-1:0] grant_one_hot_i
);

  // The consumer may only accept a grant that is actually being offered.
  a_yumi_needs_grant: assert property (
    @(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> grant_v_i
  ) else $error("yumi_i asserted while grant_v_o is low");

  // A valid grant always selects exactly one requester.
  a_one_hot: assert property (
    @(posedge clk_i) disable iff (!reset_n_i) grant_v_i |-> $onehot(grant_one_hot_i)
  ) else $error("grant_one_hot_o is not one-hot during a valid grant");

endmodule

// File: rtl/bsg_rr_pick.sv
// Rotating priority encoder: first request strictly after ptr_i, wrapping
// modulo els_p, so requester ptr_i itself is examined last.
module bsg_rr_pick
  import bsg_arb_pkg::*;
#(
  parameter int els_p = 32,
  localparam int lg_els_lp = id_width(els_p)
) (
  input  logic [els_p-1:0]     reqs_i,
  input  logic [lg_els_lp-1:0] ptr_i,
  output logic                 v_o,
  output logic [lg_els_lp-1:0] id_o
);

  logic [lg_els_lp-1:0] idx_s;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    v_o   = |reqs_i;
    id_o  = '0;
    idx_s = '0;
    for (int off = els_p; off >= 1; off--) begin
      idx_s = lg_els_lp'((int'(ptr_i) + off) % els_p);
      id_o  = reqs_i[idx_s] ? idx_s : id_o;
    end
  end

endmodule

// File: rtl/bsg_rr_decode_arb.sv
// Round-robin arbiter with a registered, sticky grant presented as a binary
// id and as one-hot select lines. The grant rotates only on yumi_i.
module bsg_rr_decode_arb
  import bsg_arb_pkg::*;
#(
  parameter int els_p = 32,
  localparam int lg_els_lp = id_width(els_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [els_p-1:0]     reqs_i,
  input  logic                 yumi_i,
  output logic                 grant_v_o,
  output logic [lg_els_lp-1:0] grant_id_o,
  output logic [els_p-1:0]     grant_one_hot_o,
  output logic [lg_els_lp-1:0] last_id_o
);

  arb_state_e           state_r, state_n_s;
  logic                 grant_v_r, grant_v_n_s;
  logic [lg_els_lp-1:0] grant_id_r, grant_id_n_s;
  logic [lg_els_lp-1:0] last_id_r, last_id_n_s;
  logic [lg_els_lp-1:0] pick_ptr_s;
  logic                 pick_v_s;
  logic [lg_els_lp-1:0] pick_id_s;

  // When retiring a grant the retiring id is the new pointer, so use it
  // directly instead of waiting a cycle for last_id_r to catch up.
  assign pick_ptr_s = (state_r == GRANT) ? grant_id_r : last_id_r;

  bsg_rr_pick #(.els_p(els_p)) pick (
    .reqs_i (reqs_i),
    .ptr_i  (pick_ptr_s),
    .v_o    (pick_v_s),
    .id_o   (pick_id_s)
  );

  // State register; reset drops any grant regardless of yumi_i.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Next-state: enter GRANT on any request, leave only on yumi with no new request.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      IDLE: begin
        if (pick_v_s) begin
          state_n_s = GRANT;
        end else begin
          state_n_s = IDLE;
        end
      end
      GRANT: begin
        if (yumi_i && !pick_v_s) begin
          state_n_s = IDLE;
        end else begin
          state_n_s = GRANT;
        end
      end
      default: state_n_s = IDLE;
    endcase
  end

  // Grant datapath next values: latch a pick in IDLE, hold in GRANT until yumi.
  always_comb begin
    grant_v_n_s  = grant_v_r;
    grant_id_n_s = grant_id_r;
    last_id_n_s  = last_id_r;
    case (state_r)
      IDLE: begin
        if (pick_v_s) begin
          grant_v_n_s  = 1'b1;
          grant_id_n_s = pick_id_s;
        end else begin
          grant_v_n_s  = 1'b0;
        end
      end
      GRANT: begin
        if (yumi_i) begin
          last_id_n_s  = grant_id_r;
          grant_v_n_s  = pick_v_s;
          grant_id_n_s = pick_v_s ? pick_id_s : grant_id_r;
        end else begin
          grant_v_n_s  = 1'b1;
        end
      end
      default: begin
        grant_v_n_s = 1'b0;
      end
    endcase
  end

  // Grant and pointer registers; pointer resets to the top id so 0 wins first.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      grant_v_r  <= 1'b0;
      grant_id_r <= '0;
      last_id_r  <= lg_els_lp'(els_p - 1);
    end else begin
      grant_v_r  <= grant_v_n_s;
      grant_id_r <= grant_id_n_s;
      last_id_r  <= last_id_n_s;
    end
  end

  assign grant_v_o  = grant_v_r;
  assign grant_id_o = grant_id_r;
  assign last_id_o  = last_id_r;

  bsg_decode_with_v #(.num_out_p(els_p)) one_hot_dec (
    .i   (grant_id_r),
    .v_i (grant_v_r),
    .o   (grant_one_hot_o)
  );

  bsg_rr_decode_arb_chk #(.els_p(els_p)) chk (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .yumi_i          (yumi_i),
    .grant_v_i       (grant_v_r),
    .grant_one_hot_i (grant_one_hot_o)
  );

endmodule

// File: tb/tb_bsg_rr_decode_arb.sv
// Scoreboard bench for bsg_rr_decode_arb: each stimulus cycle queues the
// expected post-edge outputs; a negedge monitor pops and compares.
module tb_bsg_rr_decode_arb;

  localparam int els_p = 32;
  localparam int lg_els_lp = 5;

  typedef struct {
    string      name;
    logic       v;
    logic       id_chk;
    logic [4:0] id;
    logic [4:0] last;
    logic [31:0] oh;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [els_p-1:0]  reqs = '0;
  logic              yumi = 1'b0;
  logic              grant_v;
  logic [lg_els_lp-1:0] grant_id;
  logic [els_p-1:0]  grant_one_hot;
  logic [lg_els_lp-1:0] last_id;

  exp_t q[$];
  int   n_vec = 0;
  int   n_miss = 0;
  bit   started = 1'b0;
  bit   done = 1'b0;

  bsg_rr_decode_arb #(.els_p(els_p)) dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n),
    .reqs_i          (reqs),
    .yumi_i          (yumi),
    .grant_v_o       (grant_v),
    .grant_id_o      (grant_id),
    .grant_one_hot_o (grant_one_hot),
    .last_id_o       (last_id)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue what the outputs must be after the edge.
  task automatic step(input string name, input logic rn, input logic [31:0] r,
                      input logic y, input logic ev, input logic echk,
                      input logic [4:0] eid, input logic [4:0] elast);
    exp_t e;
    reset_n = rn;
    reqs    = r;
    yumi    = y;
    e.name   = name;
    e.v      = ev;
    e.id_chk = echk;
    e.id     = eid;
    e.last   = elast;
    e.oh     = ev ? (32'h1 << eid) : 32'h0;
    q.push_back(e);
    started = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare presented outputs against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_vec++;
      if (grant_v !== e.v || grant_one_hot !== e.oh || last_id !== e.last ||
          (e.id_chk && grant_id !== e.id)) begin
        n_miss++;
        $display("FAIL %s: got v=%0b id=%0d oh=%h last=%0d, want v=%0b id=%0d oh=%h last=%0d",
                 e.name, grant_v, grant_id, grant_one_hot, last_id,
                 e.v, e.id, e.oh, e.last);
      end
    end else if (started && !done) begin
      n_vec++;
      n_miss++;
      $display("FAIL underflow: got no expectation, want one per cycle");
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset and idle.
    step("reset0", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd31);
    step("reset1", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd31);
    for (int i = 0; i < 10; i++)
      step("idle", 1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd31);

    // First grant to 0, sticky while requests change.
    step("first_grant", 1'b1, 32'h0000_0011, 1'b0, 1'b1, 1'b1, 5'd0, 5'd31);
    step("sticky0", 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 5'd0, 5'd31);
    step("sticky1", 1'b1, 32'h0000_F0F0, 1'b0, 1'b1, 1'b1, 5'd0, 5'd31);
    step("sticky2", 1'b1, 32'h0000_0002, 1'b0, 1'b1, 1'b1, 5'd0, 5'd31);
    step("sticky3", 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 5'd0, 5'd31);
    step("sticky4", 1'b1, 32'h0000_0011, 1'b0, 1'b1, 1'b1, 5'd0, 5'd31);
    step("rotate_to4", 1'b1, 32'h0000_0011, 1'b1, 1'b1, 1'b1, 5'd4, 5'd0);
    step("retire4", 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 5'd0, 5'd4);

    // Fairness: all requesting, yumi every cycle.
    step("reset2", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd31);
    step("all_first", 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 5'd0, 5'd31);
    for (int j = 0; j < 64; j++)
      step("all_rr", 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1,
           5'((j + 1) % 32), 5'(j % 32));

    // Wrap from pointer 30 across 31 to 1.
    step("to30", 1'b1, 32'h4000_0000, 1'b1, 1'b1, 1'b1, 5'd30, 5'd0);
    step("retire30", 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 5'd0, 5'd30);
    step("wrap31", 1'b1, 32'h8000_0002, 1'b0, 1'b1, 1'b1, 5'd31, 5'd30);
    step("wrap1", 1'b1, 32'h8000_0002, 1'b1, 1'b1, 1'b1, 5'd1, 5'd31);

    // Single requester 7 re-granted back-to-back, then dropped with yumi.
    step("single7_a", 1'b1, 32'h0000_0080, 1'b1, 1'b1, 1'b1, 5'd7, 5'd1);
    for (int k = 0; k < 4; k++)
      step("single7_b2b", 1'b1, 32'h0000_0080, 1'b1, 1'b1, 1'b1, 5'd7, 5'd7);
    step("single7_drop", 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 5'd0, 5'd7);
    step("idle_after7", 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 5'd0, 5'd7);

    // Reset pulse during a grant to 9 with yumi high.
    step("grant9", 1'b1, 32'h0000_0200, 1'b0, 1'b1, 1'b1, 5'd9, 5'd7);
    step("hold9", 1'b1, 32'h0000_0200, 1'b0, 1'b1, 1'b1, 5'd9, 5'd7);
    step("reset_mid", 1'b0, 32'h0000_0200, 1'b1, 1'b0, 1'b1, 5'd0, 5'd31);
    step("after_reset", 1'b1, 32'h0000_0201, 1'b0, 1'b1, 1'b1, 5'd0, 5'd31);
    step("retire0", 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
    step("final_idle", 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);

    @(negedge clk);
    #1;
    done = 1'b1;
    n_vec++;
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/bsg_rr_decode_arb.md
Name: bsg_rr_decode_arb

Overview:
- Round-robin arbiter/scheduler that shares one downstream resource among els_p requesters.
- Issues a registered, sticky grant as a binary id and as a one-hot vector; the one-hot vector is produced by the team's one-hot decoder from the binary id.
- Sits in front of a shared port (e.g. a single-ported memory bank or network link) and is used wherever one-hot select lines are needed.
- Grant is held until the downstream consumer acknowledges with yumi_i, then the grant rotates.

Parameters:
- els_p, 32, number of requesters; legal range 2..32.
- lg_els_lp, $clog2(els_p) (5 at default), width of the binary grant id; localparam.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- reset_n_i  in  1  reset, synchronous and active-low; one clock, one reset.
- reqs_i  in  els_p  request vector, bit k = requester k wants the resource.
- yumi_i  in  1  consumer accepts the current grant this cycle; legal only when grant_v_o=1.
- grant_v_o  out  1  a grant is valid.
- grant_id_o  out  lg_els_lp  binary id of the granted requester.
- grant_one_hot_o  out  els_p  one-hot of grant_id_o when grant_v_o=1; all zeros otherwise.
- last_id_o  out  lg_els_lp  id of the most recently retired grant (the priority pointer).

Behaviour:
- Reset: sampled at clk_i edge with reset_n_i=0.
  - grant_v_o=0, grant_id_o=0, grant_one_hot_o=0.
  - last_id_o=els_p-1, so requester 0 has top priority after reset.
  - FSM goes to IDLE.
- Reset asserted mid-grant: the grant is dropped at that edge; yumi_i in the same cycle is ignored.
- FSM states: IDLE, GRANT.
- Pick function: first set bit of reqs_i scanning from last_id_o+1 upward, wrapping from els_p-1 to 0. Requester last_id_o itself is lowest priority.
- IDLE:
  - If reqs_i != 0, register grant_id_o=pick, grant_v_o=1, and go to GRANT.
  - Otherwise stay in IDLE.
  - Latency from a request to grant_v_o is 1 cycle.
- GRANT, yumi_i=0:
  - Hold grant_id_o and grant_v_o.
  - The grant is sticky: requesters dropping or raising reqs_i have no effect.
- GRANT, yumi_i=1:
  - last_id_o <= grant_id_o.
  - Same cycle, re-arbitrate on the current reqs_i using the pointer value grant_id_o.
  - If any request is set: new grant next cycle, stay in GRANT (back-to-back, no bubble).
  - Otherwise go to IDLE with grant_v_o=0.
- Single requester holding its request after yumi: it is re-granted back-to-back.
- yumi_i while grant_v_o=0: illegal. Assert in simulation; the design ignores it.
- Fairness: with all requesters continuously requesting, every id is granted exactly once per els_p yumis.
- Arithmetic:
  - Pointer increment is modulo els_p, not 2^lg_els_lp; the els_p-1 → 0 wrap is required for non-power-of-two els_p.
  - Bits of reqs_i at index ≥ els_p do not exist.
- grant_one_hot_o is combinational from the registered grant_id_o and grant_v_o. There are no other combinational paths from inputs to outputs.

Decomposition:
- Shared package bsg_arb_pkg:
  - FSM state enum {IDLE, GRANT}.
  - Function to compute the id width.
- Sub-module bsg_rr_pick: combinational rotate-and-priority-encode. Inputs reqs, pointer; outputs v, id.
- One-hot generation instantiates the existing one-hot decoder on grant_id_o, gated by grant_v_o; no new decoder is written.

Test Plan:
- Reset, then reqs_i=0 for 10 cycles → grant_v_o=0, grant_one_hot_o=0, last_id_o=31.
- Set reqs_i=32'h0000_0011, no yumi → next cycle grant_id_o=0, grant_one_hot_o=32'h1, held 5 cycles while reqs_i changes. Then yumi → next cycle grant_id_o=4, one-hot 32'h10, last_id_o=0.
- reqs_i=32'hFFFF_FFFF, yumi_i=1 every granted cycle for 64 cycles → ids 0,1,...,31,0,...,31 with no bubble; one-hot equals 1<<id every cycle.
- Wrap: last_id_o=30, reqs_i=32'h8000_0002 → grant 31. After yumi → grant 1, last_id_o=31.
- Single requester 7 held high with yumi every grant → id 7 granted every cycle. Drop request together with yumi → FSM to IDLE and grant_v_o=0 next cycle.
- reset_n_i=0 pulse during GRANT (id 9) with yumi_i=1 → grant_v_o=0 next cycle, last_id_o=31, and the next request from 0 and 9 is granted to 0.
